// File: rtl/mm_pkg.sv
// mm_pkg: shared types for the matrix-multiply command scheduler.
//   WADDR_W / FADDR_W : weight / feature buffer address widths
//   CI_W / N_W        : feature-width and node-count field widths
//   mm_cmd_t          : engine configuration carried per command
//   mm_state_e        : scheduler FSM states
//   cmd_invalid()     : a command with Ci, Co or N of zero is rejected
package mm_pkg;

  localparam int WADDR_W = 13;
  localparam int FADDR_W = 11;
  localparam int CI_W    = 8;
  localparam int N_W     = 16;

  typedef struct packed {
    logic [WADDR_W-1:0] weight_addr;
    logic [FADDR_W-1:0] input_addr;
    logic [FADDR_W-1:0] output_addr;
    logic [CI_W-1:0]    ci;
    logic [CI_W-1:0]    co;
    logic [N_W-1:0]     n;
  } mm_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } mm_state_e;

  function automatic logic cmd_invalid(input mm_cmd_t c);
    return (c.ci == '0) || (c.co == '0) || (c.n == '0);
  endfunction

endpackage

// File: rtl/mm_cmd_fifo.sv
// mm_cmd_fifo: registered synchronous FIFO holding MM commands plus their tags.
// A push in cycle t is visible at the head in t+1. Push and pop may coincide.
// Ports:
//   clk, rst             clock, synchronous active-high reset (flushes the queue)
//   push, push_cmd/tag   write strobe and entry (caller guarantees !full)
//   pop                  advance the head (caller guarantees !empty)
//   head_cmd, head_tag   oldest entry
//   full, empty          occupancy flags
module mm_cmd_fifo
  import mm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  mm_cmd_t          push_cmd,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output mm_cmd_t          head_cmd,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  mm_cmd_t          mem_cmd [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  // One bit wider than the pointers so that full and empty are distinguishable.
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr] <= push_cmd;
      mem_tag[wr_ptr] <= push_tag;
    end
  end

  assign head_cmd = mem_cmd[rd_ptr];
  assign head_tag = mem_tag[rd_ptr];
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/mm_cmd_scheduler.sv
// mm_cmd_scheduler: queues MM commands from the decoder and runs them one at a
// time on the single MM engine: latch config, pulse start, wait for done, then
// post a tagged completion. Commands with Ci, Co or N of zero complete with
// cpl_err=1 without starting the engine.
// Optional feature macro: MM_SCHED_PERF_EN adds saturating perf counters
// perf_busy_cycles (cycles in ISSUE/WAIT) and perf_cmd_count (good completions).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/tag/...   decoder command channel (valid/ready handshake)
//   mm_start_valid            one-cycle engine start pulse
//   mm_*_start_addr, mm_ci,
//   mm_co, mm_n               engine config, stable from pop until the next pop
//   mm_done                   engine completion pulse
//   cpl_valid/tag/err         one-cycle completion report
//   busy                      queue non-empty or a command in progress
module mm_cmd_scheduler
  import mm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [TAG_W-1:0]   cmd_tag,
  input  logic [WADDR_W-1:0] cmd_weight_addr,
  input  logic [FADDR_W-1:0] cmd_input_addr,
  input  logic [FADDR_W-1:0] cmd_output_addr,
  input  logic [CI_W-1:0]    cmd_ci,
  input  logic [CI_W-1:0]    cmd_co,
  input  logic [N_W-1:0]     cmd_n,
  output logic               mm_start_valid,
  output logic [WADDR_W-1:0] mm_weight_start_addr,
  output logic [FADDR_W-1:0] mm_input_start_addr,
  output logic [FADDR_W-1:0] mm_output_start_addr,
  output logic [CI_W-1:0]    mm_ci,
  output logic [CI_W-1:0]    mm_co,
  output logic [N_W-1:0]     mm_n,
  input  logic               mm_done,
  output logic               cpl_valid,
  output logic [TAG_W-1:0]   cpl_tag,
  output logic               cpl_err,
  output logic               busy
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_busy_cycles,
  output logic [CNT_W-1:0]   perf_cmd_count
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
    $error("mm_cmd_scheduler: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end

  mm_state_e        state_q, state_d;
  mm_cmd_t          cfg_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  mm_cmd_t          in_cmd;
  mm_cmd_t          head_cmd;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign in_cmd = '{weight_addr: cmd_weight_addr,
                    input_addr:  cmd_input_addr,
                    output_addr: cmd_output_addr,
                    ci:          cmd_ci,
                    co:          cmd_co,
                    n:           cmd_n};

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  mm_cmd_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_cmd (in_cmd),
    .push_tag (cmd_tag),
    .pop      (pop),
    .head_cmd (head_cmd),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cfg_q <= head_cmd;
        tag_q <= head_tag;
        err_q <= cmd_invalid(head_cmd);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = cmd_invalid(head_cmd) ? ST_RETIRE : ST_ISSUE;
        end
      end
      // mm_done during ISSUE is not looked at: the engine needs at least a cycle.
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (mm_done) state_d = ST_RETIRE;
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign mm_start_valid       = (state_q == ST_ISSUE);
  assign cpl_valid            = (state_q == ST_RETIRE);
  assign cpl_err              = (state_q == ST_RETIRE) && err_q;
  assign cpl_tag              = tag_q;
  assign busy                 = !fifo_empty || (state_q != ST_IDLE);

  assign mm_weight_start_addr = cfg_q.weight_addr;
  assign mm_input_start_addr  = cfg_q.input_addr;
  assign mm_output_start_addr = cfg_q.output_addr;
  assign mm_ci                = cfg_q.ci;
  assign mm_co                = cfg_q.co;
  assign mm_n                 = cfg_q.n;

`ifdef MM_SCHED_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_cmd_count   <= '0;
    end else begin
      if (state_q == ST_ISSUE || state_q == ST_WAIT)
        perf_busy_cycles <= sat_inc(perf_busy_cycles);
      if (state_q == ST_RETIRE && !err_q)
        perf_cmd_count <= sat_inc(perf_cmd_count);
    end
  end
`endif

endmodule
